// File: rtl/mic_array_sequencer.sv
// I2S mic array frame sequencer: drives shared WS, snapshots every decoder once per frame, streams L0,R0,L1,R1,...
// Optional decoder alignment checker is compiled in with `define MIC_SYNC_CHECK_EN.
module mic_array_sequencer #(
  parameter int NUM_PAIRS = 4,
  parameter int DATAWIDTH = 24,
  parameter int CHW       = $clog2(2*NUM_PAIRS)
)(
  input  logic                           clk_mic,
  input  logic                           rst,
  input  logic                           enable,
  output logic                           ws,
  input  logic [NUM_PAIRS*DATAWIDTH-1:0] l_data,
  input  logic [NUM_PAIRS*DATAWIDTH-1:0] r_data,
  input  logic [NUM_PAIRS-1:0]           recv_over,
  output logic [DATAWIDTH-1:0]           m_data,
  output logic [CHW-1:0]                 m_chan,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           m_last,
  output logic [15:0]                    frame_cnt,
  output logic                           overrun,
  output logic                           sync_err
);
  localparam int NCH = 2*NUM_PAIRS;
  localparam logic [CHW-1:0] LAST_CH = CHW'(NCH-1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND} state_t;

  state_t                          state_q, state_d;
  logic [5:0]                      bit_cnt_q, bit_cnt_d;
  logic                            ws_q, ws_d;
  logic                            en_q, en_d;
  logic                            ro0_q, ro0_d;
  logic [CHW-1:0]                  idx_q, idx_d;
  logic [15:0]                     frame_cnt_q, frame_cnt_d;
  logic                            overrun_q, overrun_d;
  logic [NCH-1:0][DATAWIDTH-1:0]   buf_q, buf_d;
  logic                            snap, en_fall;

  always_comb begin
    // right half complete: recv_over[0] rises while WS selects the right channel
    snap        = enable && ws_q && recv_over[0] && !ro0_q;
    en_fall     = en_q && !enable;
    state_d     = state_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    overrun_d   = overrun_q;
    buf_d       = buf_q;
    en_d        = enable;
    ro0_d       = recv_over[0];
    bit_cnt_d   = enable ? bit_cnt_q + 6'd1 : 6'd0;
    ws_d        = enable ? bit_cnt_q[5] : 1'b1;
    case (state_q)
      S_IDLE: if (enable) state_d = S_WAIT;
      S_WAIT: begin
        if (!enable) state_d = S_IDLE;
        else if (snap) begin
          for (int k = 0; k < NUM_PAIRS; k++) begin
            buf_d[2*k]   = l_data[k*DATAWIDTH +: DATAWIDTH];
            buf_d[2*k+1] = r_data[k*DATAWIDTH +: DATAWIDTH];
          end
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        // buffer still streaming: the new frame is dropped, not merged
        if (snap) overrun_d = 1'b1;
        if (m_ready) begin
          if (idx_q == LAST_CH) begin
            idx_d   = '0;
            state_d = enable ? S_WAIT : S_IDLE;
          end else begin
            idx_d = idx_q + CHW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (en_fall) overrun_d = 1'b0;
  end

  always_ff @(posedge clk_mic) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      ws_q        <= 1'b1;
      en_q        <= 1'b0;
      ro0_q       <= 1'b0;
      idx_q       <= '0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      ws_q        <= ws_d;
      en_q        <= en_d;
      ro0_q       <= ro0_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clk_mic) buf_q <= buf_d;

  assign ws        = ws_q;
  assign m_valid   = (state_q == S_SEND);
  assign m_chan    = idx_q;
  assign m_data    = m_valid ? buf_q[idx_q] : '0;
  assign m_last    = m_valid && (idx_q == LAST_CH);
  assign frame_cnt = frame_cnt_q;
  assign overrun   = overrun_q;

`ifdef MIC_SYNC_CHECK_EN
  logic [NUM_PAIRS-1:1] ro_hi_q, ro_hi_d;
  logic                 sync_err_q, sync_err_d;

  always_comb begin
    ro_hi_d    = recv_over[NUM_PAIRS-1:1];
    sync_err_d = sync_err_q;
    if (snap && !(&recv_over)) sync_err_d = 1'b1;
    // another decoder finishing on its own means it is off by at least a bit
    if (enable && !recv_over[0] && |(recv_over[NUM_PAIRS-1:1] & ~ro_hi_q)) sync_err_d = 1'b1;
    if (en_fall) sync_err_d = 1'b0;
  end

  always_ff @(posedge clk_mic) begin
    if (rst) begin
      ro_hi_q    <= '0;
      sync_err_q <= 1'b0;
    end else begin
      ro_hi_q    <= ro_hi_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign sync_err = sync_err_q;
`else
  logic unused_ro;
  assign unused_ro = &{1'b0, recv_over};
  assign sync_err  = 1'b0;
`endif
endmodule

// File: tb/tb_mic_array_sequencer.sv
// Randomized bench for mic_array_sequencer: frame-level reference model with a beat queue.
module tb_mic_array_sequencer;
  localparam int NP  = 2;
  localparam int DW  = 24;
  localparam int NCH = 2*NP;
  localparam int CHW = 2;

  logic             clk_mic = 1'b0;
  logic             rst, enable, m_ready;
  logic [NP*DW-1:0] l_data, r_data;
  logic [NP-1:0]    recv_over;
  logic             ws, m_valid, m_last, overrun, sync_err;
  logic [DW-1:0]    m_data;
  logic [CHW-1:0]   m_chan;
  logic [15:0]      frame_cnt;

  always #5 clk_mic = ~clk_mic;

  mic_array_sequencer #(.NUM_PAIRS(NP), .DATAWIDTH(DW)) dut (
    .clk_mic(clk_mic), .rst(rst), .enable(enable), .ws(ws),
    .l_data(l_data), .r_data(r_data), .recv_over(recv_over),
    .m_data(m_data), .m_chan(m_chan), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .frame_cnt(frame_cnt), .overrun(overrun), .sync_err(sync_err)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference: beats still owed downstream, plus frame-level flags.
  typedef struct packed { logic [DW-1:0] d; logic [CHW-1:0] ch; } beat_t;
  beat_t    q[$];
  int       run_k, fc;
  bit       ws_e, en_prev, ovr, serr;
  bit [1:0] ro_prev;

  task automatic model_reset();
    q.delete();
    run_k = 0; ws_e = 1'b1; en_prev = 1'b0; ro_prev = '0;
    fc = 0; ovr = 1'b0; serr = 1'b0;
  endtask

  task automatic check_outputs();
    chk("ws", ws, ws_e);
    chk("m_valid", m_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("m_chan", m_chan, q[0].ch);
      chk("m_data", m_data, q[0].d);
      chk("m_last", m_last, q[0].ch == CHW'(NCH-1));
    end
    chk("frame_cnt", frame_cnt, fc & 16'hFFFF);
    chk("overrun", overrun, ovr);
    chk("sync_err", sync_err, serr);
  endtask

  // Effect of the coming posedge given the inputs now driven.
  task automatic model_edge();
    bit snap, busy;
    beat_t b;
    if (rst) begin model_reset(); return; end
    busy = q.size() > 0;
    snap = enable && ws_e && recv_over[0] && !ro_prev[0];
`ifdef MIC_SYNC_CHECK_EN
    if (snap && !recv_over[1]) serr = 1'b1;
    if (enable && recv_over[1] && !ro_prev[1] && !recv_over[0]) serr = 1'b1;
`endif
    if (snap && busy) ovr = 1'b1;
    if (busy && m_ready) void'(q.pop_front());
    if (snap && en_prev && !busy) begin
      for (int k = 0; k < NP; k++) begin
        b.d = l_data[k*DW +: DW]; b.ch = CHW'(2*k);   q.push_back(b);
        b.d = r_data[k*DW +: DW]; b.ch = CHW'(2*k+1); q.push_back(b);
      end
      fc = (fc + 1) & 16'hFFFF;
    end
    if (en_prev && !enable) begin ovr = 1'b0; serr = 1'b0; end
    if (enable) begin
      run_k++;
      ws_e = ((run_k - 1) % 64) >= 32;
    end else begin
      run_k = 0;
      ws_e  = 1'b1;
    end
    en_prev = enable;
    ro_prev = recv_over;
  endtask

  // per phase: ready %, enable-off %, recv_over toggle %, skew %, reset %, fixed data
  int ph_rdy [6] = '{100, 50,  5, 70, 90, 60};
  int ph_off [6] = '{  0,  0,  0,  3,  1,  2};
  int ph_tog [6] = '{  6,  8, 10,  8,  8,  8};
  int ph_skw [6] = '{  0,  0,  0,  0, 30, 10};
  int ph_rst [6] = '{  0,  0,  0,  0,  0,  1};

  initial begin
    bit ro0_old;
    rst = 1'b1; enable = 1'b0; m_ready = 1'b0;
    l_data = '0; r_data = '0; recv_over = '0;
    model_reset();
    repeat (3) @(posedge clk_mic);
    @(negedge clk_mic);
    chk("rst_ws", ws, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_chan", m_chan, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_sync_err", sync_err, 0);
    rst = 1'b0;

    for (int ph = 0; ph < 6; ph++) begin
      for (int cyc = 0; cyc < 600; cyc++) begin
        check_outputs();
        rst = (ph_rst[ph] > 0) && ($urandom_range(99) < ph_rst[ph]);
        if (enable) enable = !($urandom_range(99) < ph_off[ph]);
        else        enable = (ph == 0 && cyc < 2) || ($urandom_range(99) < 20);
        m_ready = $urandom_range(99) < ph_rdy[ph];
        ro0_old = recv_over[0];
        if ($urandom_range(99) < ph_tog[ph]) recv_over[0] = ~recv_over[0];
        recv_over[1] = ($urandom_range(99) < ph_skw[ph]) ? ro0_old : recv_over[0];
        if (ph == 0) begin
          l_data = {24'h000003, 24'h000001};
          r_data = {24'h000004, 24'h000002};
        end else begin
          l_data = {24'($urandom), 24'($urandom)};
          r_data = {24'($urandom), 24'($urandom)};
        end
        model_edge();
        @(negedge clk_mic);
      end
    end
    check_outputs();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
